// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch slice: FSM state encoding, default rates
// and a width helper used by every counter in the control path.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_PAUSED   = 2'd2,
    ST_CLEARING = 2'd3
  } state_e;

  localparam int unsigned DEF_CLK_HZ          = 50_000_000;
  localparam int unsigned DEF_TICK_HZ         = 1;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_key_debounce.sv
// One push-button path: 2-FF synchroniser, stability counter and a registered
// single-cycle press pulse on the accepted 1->0 level change.
module key_debounce
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  output logic press_o
);

  localparam int unsigned          CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             stable_q;
  logic             stable_d;
  logic             press_q;
  logic             press_d;

  // Counter only advances while the synced level disagrees with the accepted one.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    press_d = stable_q & ~stable_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      cnt_q    <= '0;
      stable_q <= 1'b1;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= key_n_i;
      sync2_q  <= sync1_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      press_q  <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control stage: debounced start/clear buttons, start/stop/clear FSM
// and the square-wave count clock driving the downstream time counter.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ          = DEF_CLK_HZ,
  parameter int unsigned TICK_HZ         = DEF_TICK_HZ,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_start_n,
  input  logic       key_clear_n,
  output logic       tick_out,
  output logic       tick_pulse,
  output logic       run,
  output logic       clear,
  output logic [1:0] state_o
);

  localparam int unsigned      HALF     = CLK_HZ / (2 * TICK_HZ);
  localparam int unsigned      DIV_W    = cnt_width(HALF);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF - 1);

  logic start_ev;
  logic clear_ev;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_start (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_n_i (key_start_n),
    .press_o (start_ev)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_clear (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_n_i (key_clear_n),
    .press_o (clear_ev)
  );

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic             tick_q;
  logic             tick_d;
  logic             pulse_q;
  logic             pulse_d;

  // Free-running divider; the FSM never touches it.
  always_comb begin
    div_d   = div_q + DIV_W'(1);
    tick_d  = tick_q;
    pulse_d = 1'b0;
    if (div_q == DIV_LAST) begin
      div_d   = '0;
      tick_d  = ~tick_q;
      pulse_d = ~tick_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      tick_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      tick_q  <= tick_d;
      pulse_q <= pulse_d;
    end
  end

  state_e state_q;
  state_e state_d;
  logic   entry_q;
  logic   run_q;
  logic   run_d;
  logic   clear_q;
  logic   clear_d;

  // entry_q marks the first cycle in CLEARING so a tick arriving with the entry
  // edge (clear not yet stable at the counter) is not taken as the release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      entry_q <= 1'b0;
      run_q   <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= (state_d == ST_CLEARING) && (state_q != ST_CLEARING);
      run_q   <= run_d;
      clear_q <= clear_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (clear_ev)      state_d = ST_CLEARING;
        else if (start_ev) state_d = ST_RUNNING;
      end
      ST_RUNNING: begin
        if (start_ev) state_d = ST_PAUSED;
      end
      ST_PAUSED: begin
        if (clear_ev)      state_d = ST_CLEARING;
        else if (start_ev) state_d = ST_RUNNING;
      end
      ST_CLEARING: begin
        if (pulse_q && !entry_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the next state so they change on the same edge as state_q.
  always_comb begin
    run_d   = (state_d == ST_RUNNING);
    clear_d = (state_d == ST_CLEARING);
  end

  assign tick_out   = tick_q;
  assign tick_pulse = pulse_q;
  assign run        = run_q;
  assign clear      = clear_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with a fast divider and short debounce window; a
// behavioural model is compared every cycle, plus directed literal checks.
module tb_stopwatch_ctrl;

  localparam int CLK_HZ  = 20;
  localparam int TICK_HZ = 1;
  localparam int DEB     = 4;
  localparam int HALF    = CLK_HZ / (2 * TICK_HZ);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_start_n = 1'b1;
  logic       key_clear_n = 1'b1;
  logic       tick_out;
  logic       tick_pulse;
  logic       run;
  logic       clear;
  logic [1:0] state_o;

  always #5 clk = ~clk;

  stopwatch_ctrl #(
    .CLK_HZ(CLK_HZ),
    .TICK_HZ(TICK_HZ),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_start_n (key_start_n),
    .key_clear_n (key_clear_n),
    .tick_out    (tick_out),
    .tick_pulse  (tick_pulse),
    .run         (run),
    .clear       (clear),
    .state_o     (state_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: edges since reset give the divider outputs arithmetically;
  // a button level is accepted once its last DEB synchronised samples all differ.
  int m_n;
  bit m_tick, m_pulse;
  int m_state, m_age;
  bit m_stab_s, m_stab_c, m_ev_s, m_ev_c;
  bit qs[$];
  bit qc[$];
  int o_state, n_state;
  bit o_evs, o_evc, o_pulse;

  function automatic bit flips(input bit q[$], input bit st);
    for (int k = 0; k < DEB; k++) begin
      if (q[q.size() - 3 - k] == st) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n = 0; m_tick = 0; m_pulse = 0; m_state = 0; m_age = 0;
      m_stab_s = 1; m_stab_c = 1; m_ev_s = 0; m_ev_c = 0;
      qs.delete(); qc.delete();
      for (int i = 0; i < DEB + 2; i++) begin
        qs.push_back(1'b1);
        qc.push_back(1'b1);
      end
    end else begin
      o_state = m_state; o_evs = m_ev_s; o_evc = m_ev_c; o_pulse = m_pulse;
      qs.push_back(key_start_n); void'(qs.pop_front());
      qc.push_back(key_clear_n); void'(qc.pop_front());
      m_ev_s = 0;
      if (flips(qs, m_stab_s)) begin m_ev_s = m_stab_s; m_stab_s = !m_stab_s; end
      m_ev_c = 0;
      if (flips(qc, m_stab_c)) begin m_ev_c = m_stab_c; m_stab_c = !m_stab_c; end
      m_n++;
      m_tick  = ((m_n / HALF) % 2) == 1;
      m_pulse = (m_n % (2 * HALF)) == HALF;
      n_state = o_state;
      case (o_state)
        0: if (o_evc) n_state = 3; else if (o_evs) n_state = 1;
        1: if (o_evs) n_state = 2;
        2: if (o_evc) n_state = 3; else if (o_evs) n_state = 1;
        default: if (o_pulse && m_age >= 1) n_state = 0;
      endcase
      m_age   = (n_state == 3 && o_state == 3) ? m_age + 1 : 0;
      m_state = n_state;
    end
  end

  always @(negedge clk) begin
    chk("m_tick_out", tick_out, m_tick);
    chk("m_tick_pulse", tick_pulse, m_pulse);
    chk("m_state", state_o, m_state);
    chk("m_run", run, m_state == 1);
    chk("m_clear", clear, m_state == 3);
    chk("run_clear_excl", run & clear, 0);
  end

  task automatic wait_state(input logic [1:0] s, input int max, input string nm);
    bit ok = 0;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge clk);
      if (state_o == s) ok = 1;
    end
    chk(nm, state_o, s);
  endtask

  task automatic press_start();
    key_start_n = 1'b0;
    repeat (8) @(negedge clk);
    key_start_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic press_clear();
    key_clear_n = 1'b0;
    repeat (8) @(negedge clk);
    key_clear_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int np, ntog;
    bit prev, found, run_seen;

    repeat (3) @(negedge clk);
    chk("rst_tick_out", tick_out, 0);
    chk("rst_tick_pulse", tick_pulse, 0);
    chk("rst_run", run, 0);
    chk("rst_clear", clear, 0);
    chk("rst_state", state_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    np = 0; ntog = 0; prev = tick_out;
    repeat (40) begin
      @(negedge clk);
      np += int'(tick_pulse);
      if (tick_out != prev) ntog++;
      prev = tick_out;
    end
    chk("idle_pulses", np, 2);
    chk("idle_toggles", ntog, 4);
    chk("idle_state", state_o, 0);

    key_start_n = 1'b0;
    repeat (6) @(negedge clk);
    chk("start_not_yet", run, 0);
    @(negedge clk);
    chk("start_run", run, 1);
    chk("start_state", state_o, 1);
    repeat (3) @(negedge clk);
    key_start_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("one_transition", state_o, 1);

    key_start_n = 1'b0;
    repeat (3) @(negedge clk);
    key_start_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("glitch_ignored", state_o, 1);

    press_start();
    chk("paused_state", state_o, 2);
    press_start();
    chk("resumed_state", state_o, 1);
    press_start();
    chk("paused_again", state_o, 2);
    chk("paused_run", run, 0);
    chk("paused_clear", clear, 0);

    key_clear_n = 1'b0;
    wait_state(2'd3, 12, "enter_clearing");
    key_clear_n = 1'b1;
    found = 0;
    for (int i = 0; i < 2 * HALF + 4 && !found; i++) begin
      @(negedge clk);
      if (tick_pulse && state_o == 2'd3) begin
        found = 1;
        chk("clear_at_tick_rise", clear, 1);
        chk("tick_high_at_release", tick_out, 1);
      end
    end
    chk("release_pulse_seen", found, 1);
    @(negedge clk);
    chk("cleared_state", state_o, 0);
    chk("cleared_clear", clear, 0);

    repeat (8) @(negedge clk);
    press_start();
    chk("run_again", state_o, 1);
    press_clear();
    chk("clear_ignored_state", state_o, 1);
    chk("clear_ignored_run", run, 1);
    press_start();
    chk("pause_before_clear", state_o, 2);
    key_clear_n = 1'b0;
    wait_state(2'd3, 12, "clear_from_pause");
    key_clear_n = 1'b1;
    wait_state(2'd0, 30, "back_to_idle");

    repeat (8) @(negedge clk);
    run_seen = 0;
    key_start_n = 1'b0;
    key_clear_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (run) run_seen = 1;
    end
    chk("both_clearing", state_o, 3);
    key_start_n = 1'b1;
    key_clear_n = 1'b1;
    for (int i = 0; i < 30 && state_o != 2'd0; i++) begin
      @(negedge clk);
      if (run) run_seen = 1;
    end
    chk("both_back_idle", state_o, 0);
    chk("both_no_run", run_seen, 0);

    repeat (8) @(negedge clk);
    key_clear_n = 1'b0;
    wait_state(2'd3, 12, "clearing_before_rst");
    key_clear_n = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_clear_state", state_o, 0);
    chk("rst_mid_clear_clear", clear, 0);
    chk("rst_mid_clear_tick", tick_out, 0);
    @(negedge clk);
    rst_n = 1'b1;

    key_start_n = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_deb_state", state_o, 0);
    chk("rst_mid_deb_run", run, 0);
    key_start_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("no_residual_state", state_o, 0);
    chk("no_residual_run", run, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
